// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with a combinational hit path and word-serial refill.
// Optional macro ICACHE_CRITICAL_WORD_EN: refill starts at the missed word and bypasses it to the fetcher.
module inst_cache #(
    parameter int INDEX_BITS  = 4,
    parameter int OFFSET_BITS = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        need_inst,
    input  logic [31:0] pc,
    output logic        inst_ready,
    output logic [31:0] inst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << OFFSET_BITS;
    localparam int TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS - 2;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t                  state_q, state_d;
    logic [LINES-1:0]        valid_q, valid_d;
    logic [TAG_BITS-1:0]     tag_q  [LINES];
    logic [31:0]             data_q [LINES][WORDS];
    logic [TAG_BITS-1:0]     ref_tag_q, ref_tag_d;
    logic [INDEX_BITS-1:0]   ref_idx_q, ref_idx_d;
    logic [OFFSET_BITS-1:0]  cnt_q, cnt_d, cnt_inc, start_off;
    logic                    mem_req_q, mem_req_d;
    logic [31:0]             mem_addr_q, mem_addr_d;

    logic [OFFSET_BITS-1:0]  pc_off;
    logic [INDEX_BITS-1:0]   pc_idx;
    logic [TAG_BITS-1:0]     pc_tag;
    logic                    lookup_hit, busy_line, start_refill, word_done, last_word;
    logic                    unused_pc_lsb;

    assign pc_off        = pc[OFFSET_BITS+1:2];
    assign pc_idx        = pc[INDEX_BITS+OFFSET_BITS+1:OFFSET_BITS+2];
    assign pc_tag        = pc[31:INDEX_BITS+OFFSET_BITS+2];
    assign unused_pc_lsb = ^pc[1:0];

    assign lookup_hit   = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign busy_line    = (state_q == REFILL) && (ref_idx_q == pc_idx);
    assign start_refill = (state_q == IDLE) && rdy_in && need_inst && !lookup_hit;
    assign word_done    = (state_q == REFILL) && rdy_in && mem_done;
    assign cnt_inc      = cnt_q + OFFSET_BITS'(1);

`ifdef ICACHE_CRITICAL_WORD_EN
    logic [OFFSET_BITS-1:0] start_q, start_d;
    assign start_off = pc_off;
    // Wrapped burst: the line is complete when the counter would return to its start.
    assign last_word = (cnt_inc == start_q);
`else
    assign start_off = '0;
    assign last_word = (cnt_q == {OFFSET_BITS{1'b1}});
`endif

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in)      state_q <= IDLE;
        else if (rdy_in) state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_refill)           state_d = REFILL;
            REFILL:  if (word_done && last_word) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: hit path plus optional critical-word bypass
    always_comb begin
        inst_ready = 1'b0;
        inst       = '0;
        if (!rst_in && rdy_in && need_inst) begin
            if (lookup_hit && !busy_line) begin
                inst_ready = 1'b1;
                inst       = data_q[pc_idx][pc_off];
            end
`ifdef ICACHE_CRITICAL_WORD_EN
            else if (word_done && busy_line && pc_tag == ref_tag_q && pc_off == cnt_q) begin
                inst_ready = 1'b1;
                inst       = mem_data;
            end
`endif
        end
    end

    always_comb begin
        valid_d    = valid_q;
        ref_tag_d  = ref_tag_q;
        ref_idx_d  = ref_idx_q;
        cnt_d      = cnt_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
`ifdef ICACHE_CRITICAL_WORD_EN
        start_d    = start_q;
        if (start_refill) start_d = start_off;
`endif
        if (start_refill) begin
            ref_tag_d       = pc_tag;
            ref_idx_d       = pc_idx;
            cnt_d           = start_off;
            valid_d[pc_idx] = 1'b0;
            mem_req_d       = 1'b1;
            mem_addr_d      = {pc_tag, pc_idx, start_off, 2'b00};
        end
        if (word_done) begin
            cnt_d      = cnt_inc;
            mem_addr_d = {ref_tag_q, ref_idx_q, cnt_inc, 2'b00};
            if (last_word) begin
                mem_req_d          = 1'b0;
                valid_d[ref_idx_q] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q    <= '0;
            ref_tag_q  <= '0;
            ref_idx_q  <= '0;
            cnt_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
`ifdef ICACHE_CRITICAL_WORD_EN
            start_q    <= '0;
`endif
        end else if (rdy_in) begin
            valid_q    <= valid_d;
            ref_tag_q  <= ref_tag_d;
            ref_idx_q  <= ref_idx_d;
            cnt_q      <= cnt_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
`ifdef ICACHE_CRITICAL_WORD_EN
            start_q    <= start_d;
`endif
        end
    end

    // Line storage needs no reset; the valid bits gate every read.
    always_ff @(posedge clk_in) begin
        if (!rst_in && word_done) begin
            data_q[ref_idx_q][cnt_q] <= mem_data;
            if (last_word) tag_q[ref_idx_q] <= ref_tag_q;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
endmodule
